// File: rtl/nn_pkg.sv
// Shared definitions for the NN tile sequencer slice.
//   - Default values of the sequencer parameters.
//   - FSM state encoding used by nn_tile_sequencer.
package nn_pkg;

    localparam int unsigned DEF_N_MACS    = 4;
    localparam int unsigned DEF_ACC_W     = 16;
    localparam int unsigned DEF_MEM_DEPTH = 256;
    localparam int unsigned DEF_MAX_K     = 64;
    localparam int unsigned DEF_MAX_TILES = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        OUT    = 3'd4,
        FIN    = 3'd5
    } state_e;

endpackage

// File: rtl/nn_tile_sequencer_if.sv
// Result stream between the tile sequencer and its consumer.
//   res_data  : captured accumulators, column 0 in the LSBs
//   res_tile  : index of the tile the data belongs to
//   res_valid : data held stable until res_ready is seen
//   res_ready : consumer accepts the current result
// master = sequencer side, slave = consumer side.
interface nn_tile_sequencer_if
    import nn_pkg::*;
#(
    parameter int unsigned N_MACS = DEF_N_MACS,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned TW     = $clog2(DEF_MAX_TILES + 1)
) ();

    logic [N_MACS*ACC_W-1:0] res_data;
    logic [TW-1:0]           res_tile;
    logic                    res_valid;
    logic                    res_ready;

    modport master (
        output res_data,
        output res_tile,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_data,
        input  res_tile,
        input  res_valid,
        output res_ready
    );

endinterface

// File: rtl/valid_skew_line.sv
// Systolic skew line for the MAC column valids.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : synchronous clear of every tap
//   valid_i  : enable to be skewed
//   taps_o   : taps_o[0] = valid_i delayed 1 cycle, taps_o[i] = taps_o[0] delayed i more
module valid_skew_line #(
    parameter int unsigned N_TAPS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              valid_i,
    output logic [N_TAPS-1:0] taps_o
);

    logic [N_TAPS-1:0] taps_q;
    logic [N_TAPS-1:0] taps_d;

    // Shift left by one, new sample in tap 0; the cast drops the oldest tap
    // and keeps the expression legal for a single-tap line.
    always_comb begin
        taps_d = N_TAPS'({taps_q, valid_i});
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/nn_tile_sequencer.sv
// Layer sequencer for a small MAC array: streams weight/input BRAM reads for
// each output tile, skews the column valids, waits for the array to drain and
// hands the accumulators out on a valid/ready result stream.
//   clk, rst                 : clock, synchronous active-high reset
//   start, abort             : launch a layer / cancel the current run
//   cfg_k, cfg_tiles         : reduction length and number of output tiles
//   cfg_w_base, cfg_in_base  : BRAM base addresses of weights and inputs
//   busy, done, cfg_err      : run active, completion pulse, config reject pulse
//   w_bram_addr/en           : weight BRAM read port (1-cycle latency)
//   in_bram_addr/en          : input BRAM read port (1-cycle latency)
//   mac_clear, mac_valid     : accumulator clear, skewed per-column valid
//   mac_acc_in               : accumulators from the array, column 0 in LSBs
//   res                      : result stream (master side)
module nn_tile_sequencer
    import nn_pkg::*;
#(
    parameter  int unsigned N_MACS    = DEF_N_MACS,
    parameter  int unsigned ACC_W     = DEF_ACC_W,
    parameter  int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter  int unsigned MAX_K     = DEF_MAX_K,
    parameter  int unsigned MAX_TILES = DEF_MAX_TILES,
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH),
    localparam int unsigned KW        = $clog2(MAX_K + 1),
    localparam int unsigned TW        = $clog2(MAX_TILES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [KW-1:0]           cfg_k,
    input  logic [TW-1:0]           cfg_tiles,
    input  logic [ADDR_W-1:0]       cfg_w_base,
    input  logic [ADDR_W-1:0]       cfg_in_base,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic [ADDR_W-1:0]       w_bram_addr,
    output logic                    w_bram_en,
    output logic [ADDR_W-1:0]       in_bram_addr,
    output logic                    in_bram_en,
    output logic [N_MACS-1:0]       mac_clear,
    output logic [N_MACS-1:0]       mac_valid,
    input  logic [N_MACS*ACC_W-1:0] mac_acc_in,
    nn_tile_sequencer_if.master     res
);

    // Drain counter runs 0..N_MACS.
    localparam int unsigned DW = $clog2(N_MACS + 1);

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [KW-1:0]           j_q, j_d;
    logic [TW-1:0]           tiles_q, tiles_d;
    logic [TW-1:0]           t_q, t_d;
    logic [TW-1:0]           t_inc;
    logic [DW-1:0]           d_q, d_d;
    logic [ADDR_W-1:0]       w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0]       in_ptr_q, in_ptr_d;
    logic [ADDR_W-1:0]       in_base_q, in_base_d;
    logic [N_MACS*ACC_W-1:0] res_data_q, res_data_d;
    logic [TW-1:0]           res_tile_q, res_tile_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    cfg_bad;
    logic                    streaming;

    assign cfg_bad = (cfg_k == '0) || (32'(cfg_k) > MAX_K) ||
                     (cfg_tiles == '0) || (32'(cfg_tiles) > MAX_TILES);

    assign t_inc = t_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        j_d        = j_q;
        tiles_d    = tiles_q;
        t_d        = t_q;
        d_d        = d_q;
        w_ptr_d    = w_ptr_q;
        in_ptr_d   = in_ptr_q;
        in_base_d  = in_base_q;
        res_data_d = res_data_q;
        res_tile_d = res_tile_q;
        cfg_err_d  = 1'b0;

        if (abort) begin
            // Abort wins over start and over a pending result transfer.
            state_d = IDLE;
            j_d     = '0;
            t_d     = '0;
            d_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        k_d       = cfg_k;
                        tiles_d   = cfg_tiles;
                        w_ptr_d   = cfg_w_base;
                        in_base_d = cfg_in_base;
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            state_d = CLR;
                            t_d     = '0;
                        end
                    end
                end
                CLR: begin
                    state_d  = STREAM;
                    j_d      = '0;
                    in_ptr_d = in_base_q;
                end
                STREAM: begin
                    // The weight pointer is never rewound: after k reads it
                    // already sits at w_base + (t+1)*k, the next tile's start.
                    w_ptr_d  = w_ptr_q + ADDR_W'(1);
                    in_ptr_d = in_ptr_q + ADDR_W'(1);
                    j_d      = j_q + KW'(1);
                    if (j_q == k_q - KW'(1)) begin
                        state_d = DRAIN;
                        d_d     = '0;
                    end
                end
                DRAIN: begin
                    d_d = d_q + DW'(1);
                    if (d_q == DW'(N_MACS)) begin
                        state_d    = OUT;
                        res_data_d = mac_acc_in;
                        res_tile_d = t_q;
                    end
                end
                OUT: begin
                    if (res.res_ready) begin
                        t_d     = t_inc;
                        state_d = (t_inc < tiles_q) ? CLR : FIN;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            j_q        <= '0;
            tiles_q    <= '0;
            t_q        <= '0;
            d_q        <= '0;
            w_ptr_q    <= '0;
            in_ptr_q   <= '0;
            in_base_q  <= '0;
            res_data_q <= '0;
            res_tile_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            j_q        <= j_d;
            tiles_q    <= tiles_d;
            t_q        <= t_d;
            d_q        <= d_d;
            w_ptr_q    <= w_ptr_d;
            in_ptr_q   <= in_ptr_d;
            in_base_q  <= in_base_d;
            res_data_q <= res_data_d;
            res_tile_q <= res_tile_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    valid_skew_line #(
        .N_TAPS (N_MACS)
    ) u_skew (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (abort),
        .valid_i (streaming),
        .taps_o  (mac_valid)
    );

    assign streaming    = (state_q == STREAM);
    assign busy         = (state_q != IDLE);
    // Gated so an abort landing in FIN never shows a completion.
    assign done         = (state_q == FIN) && !abort;
    assign cfg_err      = cfg_err_q;
    assign w_bram_en    = streaming;
    assign in_bram_en   = streaming;
    assign w_bram_addr  = streaming ? w_ptr_q  : '0;
    assign in_bram_addr = streaming ? in_ptr_q : '0;
    assign mac_clear    = {N_MACS{state_q == CLR}};

    assign res.res_data  = res_data_q;
    assign res.res_tile  = res_tile_q;
    assign res.res_valid = (state_q == OUT);

endmodule

// File: tb/tb_nn_tile_sequencer.sv
module tb_nn_tile_sequencer;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DEPTH = 256;
    localparam int MK    = 64;
    localparam int MT    = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int KW    = $clog2(MK + 1);
    localparam int TW    = $clog2(MT + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [KW-1:0]   cfg_k;
    logic [TW-1:0]   cfg_tiles;
    logic [AW-1:0]   cfg_w_base;
    logic [AW-1:0]   cfg_in_base;
    logic            busy, done, cfg_err;
    logic [AW-1:0]   w_bram_addr, in_bram_addr;
    logic            w_bram_en, in_bram_en;
    logic [N-1:0]    mac_clear, mac_valid;
    logic [N*W-1:0]  mac_acc_in;

    int total = 0;
    int bad   = 0;

    nn_tile_sequencer_if #(.N_MACS(N), .ACC_W(W), .TW(TW)) res_if ();

    nn_tile_sequencer #(
        .N_MACS    (N),
        .ACC_W     (W),
        .MEM_DEPTH (DEPTH),
        .MAX_K     (MK),
        .MAX_TILES (MT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_k        (cfg_k),
        .cfg_tiles    (cfg_tiles),
        .cfg_w_base   (cfg_w_base),
        .cfg_in_base  (cfg_in_base),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .w_bram_addr  (w_bram_addr),
        .w_bram_en    (w_bram_en),
        .in_bram_addr (in_bram_addr),
        .in_bram_en   (in_bram_en),
        .mac_clear    (mac_clear),
        .mac_valid    (mac_valid),
        .mac_acc_in   (mac_acc_in),
        .res          (res_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // New random accumulator value each cycle, then move to the next sample point.
    task automatic tick();
        mac_acc_in = {$urandom, $urandom};
        @(negedge clk);
    endtask

    // Full layer checked cycle by cycle against the timeline the rules imply:
    // CLR(1) -> STREAM(k) -> DRAIN(N+1) -> OUT(until ready) per tile, then FIN(1).
    task automatic run_layer(input int k, input int tiles, input int wb, input int ib,
                             input int stall_tile, input int stall_len);
        logic [63:0] exp_data;
        logic [N-1:0] ev;
        bit rdy;
        cfg_k       = KW'(k);
        cfg_tiles   = TW'(tiles);
        cfg_w_base  = AW'(wb);
        cfg_in_base = AW'(ib);
        start       = 1'b1;
        res_if.res_ready = 1'b1;
        tick();
        for (int t = 0; t < tiles; t++) begin
            check("clr_mask", 64'(mac_clear), 64'({N{1'b1}}));
            check("clr_busy", 64'(busy), 64'd1);
            check("clr_en", 64'(w_bram_en), 64'd0);
            check("clr_mvalid", 64'(mac_valid), 64'd0);
            check("clr_rvalid", 64'(res_if.res_valid), 64'd0);
            if (t == 0) begin
                // Scramble cfg after the start edge: the run must use the latched copy.
                cfg_k       = KW'($urandom);
                cfg_tiles   = TW'($urandom);
                cfg_w_base  = AW'($urandom);
                cfg_in_base = AW'($urandom);
            end
            tick();
            for (int p = 0; p <= k + N; p++) begin
                if (t == 0 && p == 0) start = 1'b0;
                check("w_en", 64'(w_bram_en), 64'(p < k));
                check("in_en", 64'(in_bram_en), 64'(p < k));
                if (p < k) begin
                    check("w_addr", 64'(w_bram_addr), 64'((wb + t * k + p) % DEPTH));
                    check("in_addr", 64'(in_bram_addr), 64'((ib + p) % DEPTH));
                end
                for (int c = 0; c < N; c++) ev[c] = (p >= c + 1) && (p <= c + k);
                check("mac_valid", 64'(mac_valid), 64'(ev));
                check("no_clear", 64'(mac_clear), 64'd0);
                check("no_rvalid", 64'(res_if.res_valid), 64'd0);
                tick();
            end
            exp_data = mac_acc_in;
            for (int o = 0; ; o++) begin
                check("out_valid", 64'(res_if.res_valid), 64'd1);
                check("out_tile", 64'(res_if.res_tile), 64'(t));
                check("out_data", 64'(res_if.res_data), exp_data);
                check("out_noclr", 64'(mac_clear), 64'd0);
                rdy = !(t == stall_tile && o < stall_len);
                res_if.res_ready = rdy;
                tick();
                if (rdy) break;
            end
        end
        res_if.res_ready = 1'b1;
        check("fin_done", 64'(done), 64'd1);
        check("fin_busy", 64'(busy), 64'd1);
        tick();
        check("done_len", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_err(input int k, input int tiles);
        cfg_k       = KW'(k);
        cfg_tiles   = TW'(tiles);
        cfg_w_base  = AW'($urandom);
        cfg_in_base = AW'($urandom);
        start       = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", 64'(cfg_err), 64'd1);
        check("err_busy", 64'(busy), 64'd0);
        tick();
        check("err_len", 64'(cfg_err), 64'd0);
        check("err_idle", 64'(busy), 64'd0);
    endtask

    typedef struct {
        int k;
        int tiles;
        int wb;
        int ib;
        int stall_tile;
        int stall_len;
        bit err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int done_seen;
        vecs[0] = '{k:3,  tiles:2,  wb:'h10, ib:'h40, stall_tile:-1, stall_len:0, err:0};
        vecs[1] = '{k:2,  tiles:2,  wb:'h80, ib:'h05, stall_tile:0,  stall_len:5, err:0};
        vecs[2] = '{k:4,  tiles:1,  wb:'hFE, ib:'hFD, stall_tile:-1, stall_len:0, err:0};
        vecs[3] = '{k:0,  tiles:2,  wb:0,    ib:0,    stall_tile:-1, stall_len:0, err:1};
        vecs[4] = '{k:3,  tiles:17, wb:0,    ib:0,    stall_tile:-1, stall_len:0, err:1};
        vecs[5] = '{k:65, tiles:1,  wb:0,    ib:0,    stall_tile:-1, stall_len:0, err:1};
        vecs[6] = '{k:2,  tiles:0,  wb:0,    ib:0,    stall_tile:-1, stall_len:0, err:1};
        vecs[7] = '{k:64, tiles:1,  wb:'hF0, ib:'h00, stall_tile:-1, stall_len:0, err:0};
        vecs[8] = '{k:1,  tiles:16, wb:'h33, ib:'h77, stall_tile:15, stall_len:2, err:0};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_k = '0; cfg_tiles = '0; cfg_w_base = '0; cfg_in_base = '0;
        mac_acc_in = '0;
        res_if.res_ready = 1'b1;
        repeat (3) tick();
        check("rst_ctrl", 64'({busy, done, cfg_err, w_bram_en, in_bram_en}), 64'd0);
        check("rst_addr", 64'({w_bram_addr, in_bram_addr}), 64'd0);
        check("rst_mac", 64'({mac_clear, mac_valid}), 64'd0);
        check("rst_res", 64'({res_if.res_valid, res_if.res_tile}), 64'd0);
        check("rst_data", 64'(res_if.res_data), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy), 64'd0);

        foreach (vecs[i]) begin
            if (vecs[i].err) run_err(vecs[i].k, vecs[i].tiles);
            else run_layer(vecs[i].k, vecs[i].tiles, vecs[i].wb, vecs[i].ib,
                           vecs[i].stall_tile, vecs[i].stall_len);
        end

        // Abort in mid-STREAM.
        cfg_k = KW'(8); cfg_tiles = TW'(2); cfg_w_base = AW'('h20); cfg_in_base = AW'('h30);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("ab_streaming", 64'(w_bram_en), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_en", 64'({w_bram_en, in_bram_en}), 64'd0);
        check("ab_mvalid", 64'(mac_valid), 64'd0);
        check("ab_rvalid", 64'(res_if.res_valid), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("ab_no_done", 64'(done_seen), 64'd0);
        check("ab_idle", 64'(busy), 64'd0);
        run_layer(5, 2, 'h20, 'h30, -1, 0);

        // Abort beats a simultaneous start.
        cfg_k = KW'(2); cfg_tiles = TW'(1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("ab_start_busy", 64'(busy), 64'd0);
        check("ab_start_err", 64'(cfg_err), 64'd0);

        // Abort beats a result transfer on the last tile: no FIN, no done.
        cfg_k = KW'(1); cfg_tiles = TW'(1); cfg_w_base = '0; cfg_in_base = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("ab_out_valid", 64'(res_if.res_valid), 64'd1);
        res_if.res_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_out_busy", 64'(busy), 64'd0);
        check("ab_out_done", 64'(done), 64'd0);
        check("ab_out_rvalid", 64'(res_if.res_valid), 64'd0);
        tick();
        check("ab_out_done2", 64'(done), 64'd0);

        // Randomized layers.
        for (int r = 0; r < 8; r++) begin
            int k, tl, wb, ib, st, sl;
            k  = int'($urandom_range(1, 12));
            tl = int'($urandom_range(1, 4));
            wb = int'($urandom_range(0, DEPTH - 1));
            ib = int'($urandom_range(0, DEPTH - 1));
            st = int'($urandom_range(0, tl - 1));
            sl = int'($urandom_range(0, 3));
            run_layer(k, tl, wb, ib, st, sl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_tile_sequencer.md
NN_TILE_SEQUENCER -- requirements
Module: nn_tile_sequencer

Interface
REQ-001 SHALL have parameter N_MACS, default 4: MAC columns driven per tile.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator width per MAC.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: BRAM depth. ADDR_W = clog2(MEM_DEPTH).
REQ-004 SHALL have parameter MAX_K, default 64: maximum reduction length. KW = clog2(MAX_K+1).
REQ-005 SHALL have parameter MAX_TILES, default 16: maximum output tiles per layer. TW = clog2(MAX_TILES+1).
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have ports start and abort, input, 1 each: start a layer; cancel the current run.
REQ-009 SHALL have ports cfg_k (input, KW), cfg_tiles (input, TW), cfg_w_base (input, ADDR_W) and cfg_in_base (input, ADDR_W): layer configuration.
REQ-010 SHALL have ports busy, done and cfg_err, output, 1 each: run active; one-cycle completion pulse; one-cycle configuration-reject pulse.
REQ-011 SHALL have ports w_bram_addr (output, ADDR_W) and w_bram_en (output, 1): weight BRAM read port, 1-cycle read latency.
REQ-012 SHALL have ports in_bram_addr (output, ADDR_W) and in_bram_en (output, 1): input BRAM read port, 1-cycle read latency.
REQ-013 SHALL have ports mac_clear (output, N_MACS) and mac_valid (output, N_MACS): accumulator clear; per-column skewed valid.
REQ-014 SHALL have port mac_acc_in, input, N_MACS*ACC_W: accumulator values from the MAC array; column 0 in the LSBs.
REQ-015 SHALL have ports res_data (output, N_MACS*ACC_W), res_tile (output, TW), res_valid (output, 1) and res_ready (input, 1): result stream.

Function
REQ-016 SHALL implement the FSM states IDLE, CLR, STREAM, DRAIN, OUT and FIN.
REQ-017 In IDLE, start=1 SHALL latch all cfg_* inputs. If cfg_k is 0 or greater than MAX_K, or cfg_tiles is 0 or greater than MAX_TILES, it SHALL pulse cfg_err for 1 cycle and stay in IDLE; otherwise it SHALL enter CLR.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 CLR SHALL last 1 cycle with mac_clear = all ones, then go to STREAM.
REQ-020 STREAM SHALL last exactly cfg_k cycles with w_bram_en = in_bram_en = 1.
REQ-021 During STREAM, in_bram_addr SHALL equal in_base + j and w_bram_addr SHALL equal w_base + t*cfg_k + j, where j is the in-tile index and t the tile index.
REQ-022 The weight address SHALL be produced from a running pointer, not a multiplier; all address arithmetic SHALL wrap modulo MEM_DEPTH.
REQ-023 mac_valid[0] SHALL be the BRAM enable delayed 1 cycle. mac_valid[i] SHALL be mac_valid[0] delayed a further i cycles (systolic skew).
REQ-024 DRAIN SHALL last N_MACS+1 cycles, after which every column has seen its last valid plus one accumulate cycle.
REQ-025 On entry to OUT, the block SHALL capture mac_acc_in into res_data and t into res_tile, and assert res_valid.
REQ-026 res_data and res_tile SHALL remain stable while res_valid=1 and res_ready=0.
REQ-027 A transfer SHALL occur on res_valid & res_ready. After it, t SHALL increment; if t+1 < cfg_tiles the FSM SHALL go to CLR, else to FIN.
REQ-028 FIN SHALL pulse done for 1 cycle, then return to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Minimum tile period SHALL be 1 + cfg_k + (N_MACS+1) + 1 cycles (res_ready held high).
REQ-031 abort=1 in any state SHALL move the FSM to IDLE on the next edge, drop all enables, valids and res_valid, clear the skew pipeline, and emit no done.
REQ-032 abort SHALL take priority over a simultaneous res_ready transfer and over start.
REQ-033 mac_clear SHALL be 0 outside CLR.

Reset
REQ-034 On rst, the block SHALL enter IDLE with all outputs 0 (busy, done, cfg_err, enables, addresses, mac_clear, mac_valid, res_valid, res_data, res_tile), all counters 0 and the skew shift register cleared.

Structure
REQ-035 A shared package nn_pkg SHALL hold the FSM state enum and the default parameter constants (N_MACS, ACC_W, MEM_DEPTH, MAX_K, MAX_TILES).
REQ-036 One sub-module, valid_skew_line, SHALL exist: an N_MACS-tap shift register producing mac_valid, with synchronous clear.

Verification
REQ-037 Bench SHALL run cfg_k=3, cfg_tiles=2, w_base=0x10, in_base=0x40, res_ready=1 and check: w addr 10,11,12 then 13,14,15; in addr 40,41,42 twice; res_tile 0 then 1; done exactly 1 cycle after the second transfer.
REQ-038 Bench SHALL check skew: with N_MACS=4, mac_valid[3] first rises 4 cycles after w_bram_en first rises and stays high 3 cycles.
REQ-039 Bench SHALL check backpressure: res_ready=0 for 5 cycles in OUT gives res_data stable, no CLR, and the next tile starting 1 cycle after the transfer.
REQ-040 Bench SHALL check config errors: cfg_k=0 gives cfg_err=1 for 1 cycle and busy=0; cfg_tiles=17 with MAX_TILES=16 does the same.
REQ-041 Bench SHALL check wrap: w_base=0xFE, cfg_k=4 gives w addr FE,FF,00,01.
REQ-042 Bench SHALL check abort in mid-STREAM: next cycle busy=0, enables=0, mac_valid=0 within 1 cycle, no done; a fresh start then runs normally.
